// File: rtl/ca_pkg.sv
// Shared constants, memory request bundle and helpers for the
// cellular-automaton display scheduler.
package ca_pkg;

    localparam int H_ACTIVE   = 640;
    localparam int V_ACTIVE   = 480;
    localparam int H_TOTAL    = 800;
    localparam int V_TOTAL    = 525;
    localparam int CELL_SHIFT = 4;

    localparam int CELL_DW = 8;
    localparam int CELL_AW = 11;

    typedef struct packed {
        logic               en;
        logic               we;
        logic [CELL_AW-1:0] addr;
        logic [CELL_DW-1:0] wdata;
    } mem_req_t;

    typedef enum logic {
        ENG_IDLE,
        ENG_BUSY
    } eng_state_t;

    function automatic logic [9:0] next_line(input logic [9:0] y);
        return (y == 10'(V_TOTAL - 1)) ? 10'd0 : y + 10'd1;
    endfunction

endpackage

// File: rtl/ca_disp_addr_gen.sv
// Display fetch trigger and incremental cell address generation,
// derived from the VGA counters without any multiplier.
module ca_disp_addr_gen
    import ca_pkg::*;
#(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_tick,
    input  logic [9:0]        X,
    input  logic [9:0]        Y,
    output logic              fetch_pend,
    output logic [ADDR_W-1:0] disp_addr
);

    localparam logic [9:0] V_LIM = 10'(ROWS << CELL_SHIFT);

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] next_base;
    logic [9:0]        ny;
    logic              in_line;
    logic              line_end;
    logic              hit;

    // Triggers sit two pixels before a cell boundary so the data is
    // buffered by the time the boundary pixel arrives.
    always_comb begin
        ny        = next_line(Y);
        in_line   = (X <= 10'(H_ACTIVE - 2))
                  && (X[CELL_SHIFT-1:0] == CELL_SHIFT'(14))
                  && (Y < V_LIM);
        line_end  = (X == 10'(H_TOTAL - 2));
        next_base = row_base;
        if (Y == 10'(V_TOTAL - 1)) begin
            next_base = '0;
        end else if (ny[CELL_SHIFT-1:0] == '0) begin
            next_base = row_base + ADDR_W'(COLS);
        end
        hit = pix_tick && (in_line || (line_end && (ny < V_LIM)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_base   <= '0;
            disp_addr  <= '0;
            fetch_pend <= 1'b0;
        end else begin
            fetch_pend <= hit;
            if (pix_tick && line_end) begin
                row_base  <= next_base;
                disp_addr <= next_base;
            end else if (pix_tick && in_line) begin
                disp_addr <= disp_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/ca_display_scheduler.sv
// Cell RAM arbiter between VGA scan-out and the CA engine, plus
// per-frame generation launch and overrun tracking.
module ca_display_scheduler
    import ca_pkg::*;
#(
    parameter int REGISTER_LENGTH = CELL_DW,
    parameter int COLS            = 40,
    parameter int ROWS            = 30,
    parameter int ADDR_W          = CELL_AW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_tick,
    input  logic [9:0]                 X,
    input  logic [9:0]                 Y,
    output logic [REGISTER_LENGTH-1:0] state,
    output logic                       gen_start,
    input  logic                       gen_done,
    output logic                       frame_overrun,
    input  logic                       eng_req,
    input  logic                       eng_we,
    input  logic [ADDR_W-1:0]          eng_addr,
    input  logic [REGISTER_LENGTH-1:0] eng_wdata,
    output logic                       eng_gnt,
    output logic                       eng_rvalid,
    output logic [REGISTER_LENGTH-1:0] eng_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [REGISTER_LENGTH-1:0] mem_wdata,
    input  logic [REGISTER_LENGTH-1:0] mem_rdata
);

    logic                       fetch_pend;
    logic [ADDR_W-1:0]          disp_addr;
    logic                       disp_cap;
    logic                       buf_valid;
    logic [REGISTER_LENGTH-1:0] disp_buf;
    logic                       slot;
    eng_state_t                 eng_st;
    mem_req_t                   req;

    ca_disp_addr_gen #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .pix_tick   (pix_tick),
        .X          (X),
        .Y          (Y),
        .fetch_pend (fetch_pend),
        .disp_addr  (disp_addr)
    );

    // Gated by reset so a held request is never granted during reset.
    assign eng_gnt = rst && eng_req && !fetch_pend;

    always_comb begin
        req = '0;
        unique case (1'b1)
            fetch_pend: begin
                req.en   = 1'b1;
                req.addr = disp_addr;
            end
            eng_gnt: begin
                req.en    = 1'b1;
                req.we    = eng_we;
                req.addr  = eng_addr;
                req.wdata = eng_wdata;
            end
            default: ;
        endcase
    end

    assign mem_en    = req.en;
    assign mem_we    = req.we;
    assign mem_addr  = req.addr;
    assign mem_wdata = req.wdata;
    assign eng_rdata = eng_rvalid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_cap   <= 1'b0;
            buf_valid  <= 1'b0;
            disp_buf   <= '0;
            state      <= '0;
            eng_rvalid <= 1'b0;
        end else begin
            disp_cap   <= fetch_pend;
            eng_rvalid <= eng_gnt && !eng_we;
            if (disp_cap) begin
                disp_buf  <= mem_rdata;
                buf_valid <= 1'b1;
            end else if (pix_tick && buf_valid) begin
                state     <= disp_buf;
                buf_valid <= 1'b0;
            end
        end
    end

    assign slot = pix_tick
                && (X == 10'(H_TOTAL - 1))
                && (Y == 10'(V_ACTIVE - 1));

    // A done pulse landing on the slot itself counts as done first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            eng_st        <= ENG_IDLE;
            gen_start     <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            gen_start <= 1'b0;
            unique case (eng_st)
                ENG_IDLE: begin
                    if (slot) begin
                        gen_start <= 1'b1;
                        eng_st    <= ENG_BUSY;
                    end
                end
                ENG_BUSY: begin
                    if (slot && gen_done) begin
                        gen_start <= 1'b1;
                    end else if (slot) begin
                        frame_overrun <= 1'b1;
                    end else if (gen_done) begin
                        eng_st <= ENG_IDLE;
                    end
                end
                default: eng_st <= ENG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ca_display_scheduler.sv
// Scoreboard bench for ca_display_scheduler: stimulus pushes expected
// RAM accesses, read data, state values and generation pulses.
module tb_ca_display_scheduler;

    localparam int DW = 8;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pix_tick = 1'b0;
    logic [9:0]    X = '0;
    logic [9:0]    Y = '0;
    logic          gen_done = 1'b0;
    logic          eng_req = 1'b0;
    logic          eng_we = 1'b0;
    logic [AW-1:0] eng_addr = '0;
    logic [DW-1:0] eng_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] state;
    logic          gen_start;
    logic          frame_overrun;
    logic          eng_gnt;
    logic          eng_rvalid;
    logic [DW-1:0] eng_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    ca_display_scheduler #(
        .REGISTER_LENGTH (DW),
        .COLS            (40),
        .ROWS            (30),
        .ADDR_W          (AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pix_tick      (pix_tick),
        .X             (X),
        .Y             (Y),
        .state         (state),
        .gen_start     (gen_start),
        .gen_done      (gen_done),
        .frame_overrun (frame_overrun),
        .eng_req       (eng_req),
        .eng_we        (eng_we),
        .eng_addr      (eng_addr),
        .eng_wdata     (eng_wdata),
        .eng_gnt       (eng_gnt),
        .eng_rvalid    (eng_rvalid),
        .eng_rdata     (eng_rdata),
        .mem_en        (mem_en),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 5 + 17);
    endfunction

    logic [DW-1:0] ram [0:2047];
    initial for (int i = 0; i < 2048; i++) ram[i] = pat(i);

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int tests = 0;
    int fails = 0;

    logic [20:0] q_mem[$];
    logic [7:0]  q_rd[$];
    logic [19:0] q_gen[$];
    logic [7:0]  q_state[$];

    bit   mon_en = 1'b0;
    logic tick_d = 1'b0;

    logic [7:0] exp_state = '0;
    logic [7:0] st_buf = '0;
    bit         st_v = 1'b0;
    bit         exp_idle = 1'b1;
    bit         exp_ovr = 1'b0;

    task automatic check(input string n, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", n, act, exp);
        end
    endtask

    task automatic unexp(input string n, input logic [63:0] act);
        tests++;
        fails++;
        $display("FAIL %s: got %0h want none", n, act);
    endtask

    always @(posedge clk) tick_d <= pix_tick;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_en) begin
                if (q_mem.size() == 0)
                    unexp("mem_access", {eng_gnt, mem_we, mem_addr, mem_wdata});
                else
                    check("mem_access", {eng_gnt, mem_we, mem_addr, mem_wdata},
                          q_mem.pop_front());
            end
            if (eng_rvalid) begin
                if (q_rd.size() == 0) unexp("eng_rvalid", eng_rdata);
                else check("eng_rdata", eng_rdata, q_rd.pop_front());
            end
            if (gen_start) begin
                if (q_gen.size() == 0) unexp("gen_start", {X, Y});
                else check("gen_start_xy", {X, Y}, q_gen.pop_front());
            end
            if (tick_d) begin
                if (q_state.size() == 0) unexp("state", state);
                else check("state", state, q_state.pop_front());
            end
        end
    end

    task automatic tick(input int x, input int y, input bit done,
                        input bit collide);
        int a;
        int ny;
        bit fetch;
        int waited;
        if (st_v) begin
            exp_state = st_buf;
            st_v = 1'b0;
        end
        q_state.push_back(exp_state);
        fetch = 1'b0;
        a = 0;
        if (x <= 638 && (x % 16) == 14 && y < 480) begin
            fetch = 1'b1;
            a = (y / 16) * 40 + (x + 2) / 16;
        end
        if (x == 798) begin
            ny = (y == 524) ? 0 : y + 1;
            if (ny < 480) begin
                fetch = 1'b1;
                a = (ny / 16) * 40;
            end
        end
        if (fetch) begin
            q_mem.push_back({2'b00, 11'(a), 8'h00});
            st_buf = pat(a);
            st_v = 1'b1;
        end
        if (done) exp_idle = 1'b1;
        if (x == 799 && y == 479) begin
            if (exp_idle) begin
                q_gen.push_back({10'd799, 10'd479});
                exp_idle = 1'b0;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        X = 10'(x);
        Y = 10'(y);
        pix_tick = 1'b1;
        gen_done = done;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        gen_done = 1'b0;
        if (collide) begin
            q_mem.push_back({2'b10, 11'd5, 8'h00});
            q_rd.push_back(pat(5));
            eng_req = 1'b1;
            eng_we = 1'b0;
            eng_addr = 11'd5;
            waited = 0;
            @(negedge clk);
            while (!eng_gnt && waited < 4) begin
                waited++;
                @(negedge clk);
            end
            check("collide_wait", waited, 1);
            @(posedge clk);
            #1;
            eng_req = 1'b0;
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic eng_op(input bit we, input int a, input logic [7:0] wd,
                          input logic [7:0] rd_exp);
        int waited;
        waited = 0;
        q_mem.push_back({1'b1, we, 11'(a), wd});
        if (!we) q_rd.push_back(rd_exp);
        @(posedge clk);
        #1;
        eng_req = 1'b1;
        eng_we = we;
        eng_addr = 11'(a);
        eng_wdata = wd;
        @(negedge clk);
        while (!eng_gnt && waited < 4) begin
            waited++;
            @(negedge clk);
        end
        check("eng_wait", waited, 0);
        @(posedge clk);
        #1;
        eng_req = 1'b0;
        eng_we = 1'b0;
        eng_wdata = '0;
        repeat (2) @(posedge clk);
    endtask

    // mode: 0 no done, 1 done early in frame, 2 done on the slot tick
    task automatic frame(input bit full, input int mode);
        for (int y = 0; y < 525; y++) begin
            if (full && (y == 17 || y == 479)) begin
                for (int c = 0; c < 40; c++) begin
                    tick(16 * c + 14, y, 1'b0, (y == 17) && (c == 2));
                    tick(16 * c + 15, y, 1'b0, 1'b0);
                end
            end
            tick(798, y, (mode == 1) && (y == 100), 1'b0);
            tick(799, y, (mode == 2) && (y == 479), 1'b0);
            if (y == 479) begin
                check("overrun", frame_overrun, exp_ovr);
                check("gen_missing", q_gen.size(), 0);
            end
        end
    endtask

    function automatic logic [63:0] outs();
        return {state, gen_start, frame_overrun, eng_gnt, eng_rvalid,
                eng_rdata, mem_en, mem_we, mem_addr, mem_wdata};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", outs(), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        X = 10'd14;
        Y = 10'd100;
        pix_tick = 1'b1;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        eng_req = 1'b1;
        eng_we = 1'b0;
        eng_addr = 11'd9;
        @(posedge clk);
        #2;
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("midreset_outs", outs(), 0);
        repeat (3) @(posedge clk);
        #1;
        eng_req = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        check("post_reset_outs", outs(), 0);

        tick(14, 500, 1'b0, 1'b0);
        tick(798, 500, 1'b0, 1'b0);
        tick(798, 524, 1'b0, 1'b0);
        tick(799, 524, 1'b0, 1'b0);

        frame(1'b1, 0);
        frame(1'b0, 1);
        frame(1'b0, 0);
        frame(1'b0, 1);
        frame(1'b0, 2);

        eng_op(1'b1, 7, 8'hC3, 8'h00);
        eng_op(1'b0, 7, 8'h00, 8'hC3);
        eng_op(1'b0, 6, 8'h00, 8'h2F);

        repeat (5) @(posedge clk);
        check("q_mem_left", q_mem.size(), 0);
        check("q_rd_left", q_rd.size(), 0);
        check("q_gen_left", q_gen.size(), 0);
        check("q_state_left", q_state.size(), 0);
        check("overrun_final", frame_overrun, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
